// File: rtl/id_issue_scoreboard.sv
// ID-stage issue controller: holds the ID instruction on register and
// write-port hazards, reserves write-back slots and drives the RF write port.
module id_issue_scoreboard #(
    parameter int LAT_MAX = 4,
    parameter int LW      = $clog2(LAT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [4:0]    id_rs1,
    input  logic [4:0]    id_rs2,
    input  logic [4:0]    id_rd,
    input  logic          id_uses_rs1,
    input  logic          id_uses_rs2,
    input  logic          id_writes_rd,
    input  logic [LW-1:0] id_lat,
    input  logic          flush,
    output logic          issue,
    output logic          stall,
    output logic          RegWrite,
    output logic [4:0]    WriteReg,
    output logic [31:0]   pending,
    output logic [15:0]   stall_cnt
);

    // Slot k (1-based) lives at index k-1; index 0 is the write-back slot.
    logic [LAT_MAX-1:0] v_q, v_d;
    logic [4:0]         rd_q [LAT_MAX];
    logic [4:0]         rd_d [LAT_MAX];
    logic [15:0]        cnt_q, cnt_d;

    logic [LW-1:0] lat_eff;
    logic          wr_nz;
    logic          raw, waw, port, port_busy;
    logic          alloc;

    // Clamp the requested latency into 1..LAT_MAX
    always_comb begin
        if (id_lat == '0)
            lat_eff = LW'(1);
        else if (int'(id_lat) > LAT_MAX)
            lat_eff = LW'(LAT_MAX);
        else
            lat_eff = id_lat;
    end

    // Reserved destinations, including the slot writing back this cycle
    always_comb begin
        pending = '0;
        for (int k = 0; k < LAT_MAX; k++)
            if (v_q[k]) pending[rd_q[k]] = 1'b1;
    end

    // Write port is busy if slot L+1 is taken (it lands in slot L after shift)
    always_comb begin
        port_busy = 1'b0;
        for (int k = 0; k < LAT_MAX; k++)
            if (k == int'(lat_eff)) port_busy = v_q[k];
    end

    assign wr_nz = id_writes_rd && (id_rd != 5'd0);

    assign raw = (id_uses_rs1 && (id_rs1 != 5'd0) && pending[id_rs1])
              || (id_uses_rs2 && (id_rs2 != 5'd0) && pending[id_rs2]);
    assign waw  = wr_nz && pending[id_rd];
    assign port = wr_nz && port_busy;

    assign stall = rst && id_valid && !flush && (raw || waw || port);
    assign issue = rst && id_valid && !flush && !stall;
    assign alloc = issue && wr_nz;

    // Shift reservations toward write-back, then place the new one at slot L
    always_comb begin
        for (int k = 0; k < LAT_MAX - 1; k++) begin
            v_d[k]  = v_q[k+1];
            rd_d[k] = rd_q[k+1];
        end
        v_d[LAT_MAX-1]  = 1'b0;
        rd_d[LAT_MAX-1] = 5'd0;
        if (alloc) begin
            for (int k = 0; k < LAT_MAX; k++) begin
                if (k + 1 == int'(lat_eff)) begin
                    v_d[k]  = 1'b1;
                    rd_d[k] = id_rd;
                end
            end
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    // Reservation array and counter; reset drops any in-flight write-backs
    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int k = 0; k < LAT_MAX; k++)
                rd_q[k] <= 5'd0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < LAT_MAX; k++)
                rd_q[k] <= rd_d[k];
        end
    end

    assign RegWrite  = v_q[0];
    assign WriteReg  = v_q[0] ? rd_q[0] : 5'd0;
    assign stall_cnt = cnt_q;

endmodule
